// File: rtl/dsp_sched.sv
// dsp_sched: round-robin time-sliced sharing of one 4-digit 7-segment display
// between four requesters. The granted owner's frame is registered onto d3..d0.
module dsp_sched #(
  parameter int          SLICE = 8,
  parameter logic [7:0]  BLANK = 8'h00
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic [3:0]   req,
  input  logic [127:0] frame,
  output logic [3:0]   gnt,
  output logic         busy,
  output logic [7:0]   d3,
  output logic [7:0]   d2,
  output logic [7:0]   d1,
  output logic [7:0]   d0
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [7:0]  SLICE_C = 8'(SLICE);
  localparam logic [31:0] BLANK_FRAME = {4{BLANK}};

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  slice_cnt_q, slice_cnt_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [31:0] disp_q, disp_d;

  logic [31:0] frame_arr [4];
  logic [1:0]  cand;
  logic [1:0]  idle_pick, pre_pick;
  logic        idle_hit, pre_hit;

  for (genvar i = 0; i < 4; i++) begin : g_unpack
    assign frame_arr[i] = frame[32*i +: 32];
  end

  // Candidate search: first requester from ptr upward, and first other requester after the owner
  always_comb begin
    cand      = 2'd0;
    idle_pick = 2'd0;
    idle_hit  = 1'b0;
    pre_pick  = 2'd0;
    pre_hit   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!idle_hit && req[cand]) begin
        idle_hit  = 1'b1;
        idle_pick = cand;
      end
    end
    for (int k = 1; k < 4; k++) begin
      cand = owner_q + 2'(k);
      if (!pre_hit && req[cand]) begin
        pre_hit  = 1'b1;
        pre_pick = cand;
      end
    end
  end

  // Next-state logic: grant, release, preempt or hold; display data follows the grant
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    slice_cnt_d = slice_cnt_q;
    gnt_d       = gnt_q;
    disp_d      = disp_q;
    case (state_q)
      IDLE: begin
        if (idle_hit) begin
          state_d     = OWN;
          owner_d     = idle_pick;
          gnt_d       = 4'b0001 << idle_pick;
          disp_d      = frame_arr[idle_pick];
          slice_cnt_d = 8'd0;
        end else begin
          gnt_d  = 4'b0000;
          disp_d = BLANK_FRAME;
        end
      end
      OWN: begin
        if (!req[owner_q]) begin
          state_d     = IDLE;
          gnt_d       = 4'b0000;
          disp_d      = BLANK_FRAME;
          ptr_d       = owner_q + 2'd1;
          slice_cnt_d = 8'd0;
        end else if (slice_cnt_q == SLICE_C && pre_hit) begin
          owner_d     = pre_pick;
          gnt_d       = 4'b0001 << pre_pick;
          disp_d      = frame_arr[pre_pick];
          ptr_d       = pre_pick + 2'd1;
          slice_cnt_d = 8'd0;
        end else begin
          disp_d = frame_arr[owner_q];
          if (tick && slice_cnt_q != SLICE_C) begin
            slice_cnt_d = slice_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        disp_d  = BLANK_FRAME;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      ptr_q       <= 2'd0;
      slice_cnt_q <= 8'd0;
      gnt_q       <= 4'b0000;
      disp_q      <= BLANK_FRAME;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      slice_cnt_q <= slice_cnt_d;
      gnt_q       <= gnt_d;
      disp_q      <= disp_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = |gnt_q;
  assign d3   = disp_q[31:24];
  assign d2   = disp_q[23:16];
  assign d1   = disp_q[15:8];
  assign d0   = disp_q[7:0];

endmodule

// File: tb/tb_dsp_sched.sv
// tb_dsp_sched: directed stimulus with a behavioural scheduler model and per-cycle compare
module tb_dsp_sched;

  localparam int SLICE = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick = 1'b0;
  logic [3:0]   req = 4'h0;
  logic [127:0] frame = '0;
  logic [3:0]   gnt;
  logic         busy;
  logic [7:0]   d3, d2, d1, d0;

  int num_checks = 0;
  int num_errors = 0;

  int          m_owner = -1;
  int          m_ptr = 0;
  int          m_cnt = 0;
  logic [3:0]  m_gnt = 4'h0;
  logic [31:0] m_disp = 32'h0;
  bit          model_valid = 1'b0;

  dsp_sched #(.SLICE(SLICE), .BLANK(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .req(req), .frame(frame),
    .gnt(gnt), .busy(busy), .d3(d3), .d2(d2), .d1(d1), .d0(d0)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock step from a falling edge to the next, with tick held for that edge
  task automatic applyStimulus(input logic t);
    tick = t;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Behavioural model: owner/pointer/slice bookkeeping updated from the inputs seen at each edge
  always @(posedge clk) begin
    int pick;
    pick = -1;
    if (!rst_n) begin
      m_owner = -1;
      m_ptr = 0;
      m_cnt = 0;
      model_valid = 1'b1;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++)
        if (pick < 0 && req[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
      if (pick >= 0) begin
        m_owner = pick;
        m_cnt = 0;
      end
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % 4;
      m_owner = -1;
    end else begin
      for (int k = 1; k < 4; k++)
        if (pick < 0 && req[(m_owner + k) % 4]) pick = (m_owner + k) % 4;
      if (m_cnt == SLICE && pick >= 0) begin
        m_owner = pick;
        m_ptr = (pick + 1) % 4;
        m_cnt = 0;
      end else if (tick && m_cnt < SLICE) begin
        m_cnt++;
      end
    end
    if (m_owner < 0) begin
      m_gnt = 4'h0;
      m_disp = 32'h0;
    end else begin
      m_gnt = 4'h0;
      m_gnt[m_owner] = 1'b1;
      m_disp = frame[32*m_owner +: 32];
    end
  end

  // Compare process: outputs against the model on every falling edge once reset was seen
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("model_gnt", {28'h0, gnt}, {28'h0, m_gnt});
      checkOutput("model_busy", {31'h0, busy}, {31'h0, |m_gnt});
      checkOutput("model_disp", {d3, d2, d1, d0}, m_disp);
    end
  end

  initial begin
    frame[31:0]   = 32'h11223344;
    frame[63:32]  = 32'h55667788;
    frame[95:64]  = 32'h3F065B4F;
    frame[127:96] = 32'hA1B2C3D4;

    // Reset with all requesters active
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'hF;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("reset_gnt", {28'h0, gnt}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_disp", {d3, d2, d1, d0}, 32'h00000000);
    rst_n = 1'b1;
    applyStimulus(1'b0);
    checkOutput("first_gnt", {28'h0, gnt}, 32'h1);
    checkOutput("first_disp", {d3, d2, d1, d0}, 32'h11223344);

    // Single owner keeps display indefinitely
    rst_n = 1'b0;
    applyStimulus(1'b0);
    rst_n = 1'b1;
    req = 4'b0100;
    applyStimulus(1'b0);
    checkOutput("single_gnt", {28'h0, gnt}, 32'h4);
    checkOutput("single_disp", {d3, d2, d1, d0}, 32'h3F065B4F);
    for (int i = 0; i < 1000; i++) applyStimulus(1'b1);
    checkOutput("single_hold", {28'h0, gnt}, 32'h4);

    // Round-robin preemption 0 -> 1 -> 3 -> 0
    rst_n = 1'b0;
    applyStimulus(1'b0);
    rst_n = 1'b1;
    req = 4'b1011;
    applyStimulus(1'b1);
    checkOutput("rr_start", {28'h0, gnt}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0);
      applyStimulus(1'b1);
    end
    checkOutput("rr_before_expiry", {28'h0, gnt}, 32'h1);
    applyStimulus(1'b0);
    checkOutput("rr_to_1", {28'h0, gnt}, 32'h2);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("rr_to_3", {28'h0, gnt}, 32'h8);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("rr_to_0", {28'h0, gnt}, 32'h1);

    // Release of owner 1 with requester 3 waiting: one blank cycle
    for (int i = 0; i < 8; i++) applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("rel_owner1", {28'h0, gnt}, 32'h2);
    req = 4'b1010;
    applyStimulus(1'b0);
    req = 4'b1000;
    applyStimulus(1'b0);
    checkOutput("rel_gap_gnt", {28'h0, gnt}, 32'h0);
    checkOutput("rel_gap_disp", {d3, d2, d1, d0}, 32'h00000000);
    applyStimulus(1'b0);
    checkOutput("rel_next", {28'h0, gnt}, 32'h8);

    // Release coincides with slice expiry; then tick coincident with a new grant
    req = 4'b1001;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1);
    req = 4'b0001;
    applyStimulus(1'b0);
    checkOutput("sim_release_wins", {28'h0, gnt}, 32'h0);
    applyStimulus(1'b1);
    checkOutput("sim_grant0", {28'h0, gnt}, 32'h1);
    req = 4'b0011;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("sim_tick_ignored", {28'h0, gnt}, 32'h1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("sim_preempt_late", {28'h0, gnt}, 32'h2);

    // Mid-grant reset restores pointer to 0
    rst_n = 1'b0;
    applyStimulus(1'b0);
    rst_n = 1'b1;
    req = 4'b0100;
    applyStimulus(1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1);
    checkOutput("mid_owner2", {28'h0, gnt}, 32'h4);
    rst_n = 1'b0;
    req = 4'b0101;
    applyStimulus(1'b1);
    checkOutput("mid_reset_gnt", {28'h0, gnt}, 32'h0);
    checkOutput("mid_reset_disp", {d3, d2, d1, d0}, 32'h00000000);
    rst_n = 1'b1;
    applyStimulus(1'b0);
    checkOutput("mid_ptr0_wins", {28'h0, gnt}, 32'h1);

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
